// File: rtl/test_run_pkg.sv
// Shared types for the test run sequencer: FSM states and fail-reason codes.
package test_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_RUN        = 3'd2,
        ST_PASS       = 3'd3,
        ST_FAIL       = 3'd4
    } run_state_e;

    typedef enum logic [1:0] {
        REASON_NONE    = 2'd0,
        REASON_DUT     = 2'd1,
        REASON_TIMEOUT = 2'd2,
        REASON_STALL   = 2'd3
    } fail_reason_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating up-counter with synchronous clear/enable and an equality compare
// against an external value; used as the run-cycle counter of the sequencer.
module run_cycle_counter
    import test_run_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_cmp_value,
    output logic [CNT_W-1:0] o_count,
    output logic             o_equal
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear wins over enable, holds at all-ones.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_equal = (r_count == i_cmp_value);

endmodule

// File: rtl/test_run_sequencer.sv
// Run controller for the simulation top: reset hold, run, pass/fail/timeout verdict.
// Optional stall watchdog compiled in with `define RUN_CTRL_STALL_WATCHDOG_EN.
module test_run_sequencer
    import test_run_pkg::*;
#(
    parameter int CNT_W        = 64,
    parameter int RST_W        = 16,
    parameter int STALL_CYCLES = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_max_cycles,
    input  logic [RST_W-1:0] cfg_reset_cycles,
    input  logic             dut_success,
    input  logic             dut_failure,
    input  logic             dut_progress,
    output logic             dut_reset,
    output logic             running,
    output logic             done,
    output logic             passed,
    output logic [1:0]       fail_reason,
    output logic             finish_req,
    output logic [CNT_W-1:0] cycle_count
);

    run_state_e       r_state;
    fail_reason_e     r_fail_reason;
    logic [CNT_W-1:0] r_max;
    logic [RST_W-1:0] r_hold_len;
    logic [RST_W-1:0] r_hold;
    logic             r_dut_reset;
    logic             r_running;
    logic             r_done;
    logic             r_passed;
    logic             r_finish_req;

    logic             w_start_ok;
    logic             w_cnt_enable;
    logic             w_cnt_eq;
    logic             w_stall_hit;
    logic             w_end;
    logic             w_end_fail;
    fail_reason_e     w_reason;
    logic [CNT_W-1:0] w_count;

`ifdef RUN_CTRL_STALL_WATCHDOG_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] r_stall;

    // Consecutive no-progress RUN cycles; compared before this cycle's update.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_stall <= '0;
        end else if (r_state != ST_RUN) begin
            r_stall <= '0;
        end else if (dut_progress) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign w_stall_hit = (r_stall == STALL_W'(STALL_CYCLES));
`else
    logic w_unused_progress;
    assign w_unused_progress = dut_progress | (STALL_CYCLES == 0);
    assign w_stall_hit       = 1'b0;
`endif

    run_cycle_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_start_ok),
        .i_enable    (w_cnt_enable),
        .i_cmp_value (r_max),
        .o_count     (w_count),
        .o_equal     (w_cnt_eq)
    );

    // Start acceptance and RUN outcome; the timeout cycle is not counted so the
    // frozen count equals the limit the DUT was granted.
    always_comb begin
        w_start_ok   = 1'b0;
        w_cnt_enable = 1'b0;
        w_end        = 1'b0;
        w_end_fail   = 1'b0;
        w_reason     = REASON_NONE;
        if ((r_state == ST_IDLE) || (r_state == ST_PASS) || (r_state == ST_FAIL)) begin
            w_start_ok = start;
        end else begin
            w_start_ok = 1'b0;
        end
        if (r_state == ST_RUN) begin
            w_cnt_enable = 1'b1;
            if (dut_failure) begin
                w_end      = 1'b1;
                w_end_fail = 1'b1;
                w_reason   = REASON_DUT;
            end else if (w_stall_hit) begin
                w_end      = 1'b1;
                w_end_fail = 1'b1;
                w_reason   = REASON_STALL;
            end else if ((r_max != '0) && w_cnt_eq) begin
                w_end        = 1'b1;
                w_end_fail   = 1'b1;
                w_reason     = REASON_TIMEOUT;
                w_cnt_enable = 1'b0;
            end else if (dut_success) begin
                w_end = 1'b1;
            end else begin
                w_end = 1'b0;
            end
        end else begin
            w_cnt_enable = 1'b0;
        end
    end

    // Sequencer FSM with registered state-decoded outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_fail_reason <= REASON_NONE;
            r_max         <= '0;
            r_hold_len    <= RST_W'(1);
            r_hold        <= '0;
            r_dut_reset   <= 1'b1;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
            r_passed      <= 1'b0;
            r_finish_req  <= 1'b0;
        end else begin
            r_finish_req <= 1'b0;
            case (r_state)
                ST_IDLE, ST_PASS, ST_FAIL: begin
                    if (w_start_ok) begin
                        r_state       <= ST_RESET_HOLD;
                        r_max         <= cfg_max_cycles;
                        r_hold_len    <= (cfg_reset_cycles == '0) ? RST_W'(1) : cfg_reset_cycles;
                        r_hold        <= '0;
                        r_dut_reset   <= 1'b1;
                        r_done        <= 1'b0;
                        r_passed      <= 1'b0;
                        r_fail_reason <= REASON_NONE;
                    end
                end
                ST_RESET_HOLD: begin
                    if (r_hold == (r_hold_len - RST_W'(1))) begin
                        r_state     <= ST_RUN;
                        r_dut_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold <= r_hold + RST_W'(1);
                    end
                end
                ST_RUN: begin
                    if (w_end) begin
                        r_state       <= w_end_fail ? ST_FAIL : ST_PASS;
                        r_running     <= 1'b0;
                        r_done        <= 1'b1;
                        r_passed      <= ~w_end_fail;
                        r_fail_reason <= w_reason;
                        r_finish_req  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_dut_reset <= 1'b1;
                    r_running   <= 1'b0;
                    r_done      <= 1'b0;
                    r_passed    <= 1'b0;
                end
            endcase
        end
    end

    assign dut_reset   = r_dut_reset;
    assign running     = r_running;
    assign done        = r_done;
    assign passed      = r_passed;
    assign fail_reason = r_fail_reason;
    assign finish_req  = r_finish_req;
    assign cycle_count = w_count;

endmodule

// File: tb/tb_test_run_sequencer.sv
// Randomized bench for test_run_sequencer against a cycle-by-cycle outcome model.
// Expectations follow RUN_CTRL_STALL_WATCHDOG_EN when it is defined for the build.
module tb_test_run_sequencer;

    localparam int CNT_W  = 8;
    localparam int RST_W  = 16;
    localparam int STALLC = 8;
    localparam int MAXC   = 255;
    localparam int GUARD  = 400;
`ifdef RUN_CTRL_STALL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] cfg_max_cycles = '0;
    logic [RST_W-1:0] cfg_reset_cycles = '0;
    logic             dut_success = 1'b0;
    logic             dut_failure = 1'b0;
    logic             dut_progress = 1'b0;
    logic             dut_reset;
    logic             running;
    logic             done;
    logic             passed;
    logic [1:0]       fail_reason;
    logic             finish_req;
    logic [CNT_W-1:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    test_run_sequencer #(.CNT_W(CNT_W), .RST_W(RST_W), .STALL_CYCLES(STALLC)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .cfg_max_cycles   (cfg_max_cycles),
        .cfg_reset_cycles (cfg_reset_cycles),
        .dut_success      (dut_success),
        .dut_failure      (dut_failure),
        .dut_progress     (dut_progress),
        .dut_reset        (dut_reset),
        .running          (running),
        .done             (done),
        .passed           (passed),
        .fail_reason      (fail_reason),
        .finish_req       (finish_req),
        .cycle_count      (cycle_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Outcome of a run: RUN cycle in which it ends, reason, verdict and final count.
    task automatic model(input int mx, input int succ, input int fl, input int ps,
                         output int ecyc, output int ereason, output int epass, output int ecnt);
        int stall;
        stall   = 0;
        ecyc    = GUARD + 1;
        ereason = 0;
        epass   = 0;
        ecnt    = 0;
        for (int k = 1; k <= GUARD; k++) begin
            if (k == fl) begin
                ecyc = k; ereason = 1; ecnt = sat(k); return;
            end
            if (WD && (stall == STALLC)) begin
                ecyc = k; ereason = 3; ecnt = sat(k); return;
            end
            if ((mx != 0) && (sat(k - 1) == mx)) begin
                ecyc = k; ereason = 2; ecnt = sat(k - 1); return;
            end
            if (k == succ) begin
                ecyc = k; epass = 1; ecnt = sat(k); return;
            end
            stall = ((ps == 0) || (k < ps)) ? 0 : stall + 1;
        end
    endtask

    task automatic run_case(input string tag, input int hold, input int mx, input int succ,
                            input int fl, input int ps);
        int ecyc, ereason, epass, ecnt, hold_seen, hg, k, bad;
        model(mx, succ, fl, ps, ecyc, ereason, epass, ecnt);
        cfg_reset_cycles = RST_W'(hold);
        cfg_max_cycles   = CNT_W'(mx);
        start = 1'b1;
        tick();
        start = 1'b0;
        cfg_reset_cycles = RST_W'($urandom);
        cfg_max_cycles   = CNT_W'($urandom);
        hold_seen = 0;
        hg = 0;
        while (!running && (hg < 40)) begin
            if (dut_reset && !done) hold_seen++;
            dut_success  = 1'($urandom);
            dut_failure  = 1'($urandom);
            dut_progress = 1'($urandom);
            start        = 1'($urandom);
            tick();
            hg++;
        end
        check_eq({tag, ".hold_len"}, hold_seen, (hold == 0) ? 1 : hold);
        k = 0;
        bad = 0;
        while (running && (k < GUARD)) begin
            if ((dut_reset !== 1'b0) || (finish_req !== 1'b0) || (done !== 1'b0) ||
                (int'(cycle_count) != sat(k))) bad++;
            k++;
            dut_success  = (k == succ);
            dut_failure  = (k == fl);
            dut_progress = (ps == 0) || (k < ps);
            start        = 1'($urandom);
            tick();
        end
        start = 1'b0;
        dut_success = 1'b0;
        dut_failure = 1'b0;
        check_eq({tag, ".run_cycles_bad"}, bad, 0);
        check_eq({tag, ".end_cycle"}, k, ecyc);
        check_eq({tag, ".done"}, int'(done), 1);
        check_eq({tag, ".passed"}, int'(passed), epass);
        check_eq({tag, ".reason"}, int'(fail_reason), ereason);
        check_eq({tag, ".count"}, int'(cycle_count), ecnt);
        check_eq({tag, ".finish"}, int'(finish_req), 1);
        check_eq({tag, ".dut_reset"}, int'(dut_reset), 0);
        tick();
        check_eq({tag, ".finish_once"}, int'(finish_req), 0);
        check_eq({tag, ".held"}, int'(done), 1);
        check_eq({tag, ".frozen"}, int'(cycle_count), ecnt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int hold, mx, succ, fl, ps, wg;
        reset = 1'b0;
        tick();
        tick();
        check_eq("rst.dut_reset", int'(dut_reset), 1);
        check_eq("rst.running", int'(running), 0);
        check_eq("rst.done", int'(done), 0);
        check_eq("rst.passed", int'(passed), 0);
        check_eq("rst.reason", int'(fail_reason), 0);
        check_eq("rst.finish", int'(finish_req), 0);
        check_eq("rst.count", int'(cycle_count), 0);
        reset = 1'b1;
        tick();
        check_eq("idle.dut_reset", int'(dut_reset), 1);

        run_case("t1_pass", 5, 0, 10, 0, 0);
        run_case("t2_timeout", 3, 100, 0, 0, 0);
        run_case("t3_both", 2, 0, 7, 7, 0);
        run_case("t5_restart", 0, 0, 4, 0, 0);
        run_case("t6_stall", 1, 30, 0, 0, 3);
        run_case("to_edge", 1, 12, 13, 0, 0);
        run_case("succ_at_max", 1, 12, 12, 0, 0);
        run_case("max_full", 1, 255, 0, 0, 0);
        run_case("saturate", 1, 0, 300, 0, 0);

        // Reset in the middle of a run aborts straight to IDLE.
        cfg_reset_cycles = RST_W'(2);
        cfg_max_cycles   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wg = 0;
        while (!running && (wg < 20)) begin
            tick();
            wg++;
        end
        repeat (20) tick();
        check_eq("t4.count_before", int'(cycle_count), 20);
        reset = 1'b0;
        tick();
        check_eq("t4.dut_reset", int'(dut_reset), 1);
        check_eq("t4.running", int'(running), 0);
        check_eq("t4.done", int'(done), 0);
        check_eq("t4.finish", int'(finish_req), 0);
        check_eq("t4.count", int'(cycle_count), 0);
        reset = 1'b1;
        tick();
        check_eq("t4.idle_done", int'(done), 0);
        check_eq("t4.idle_finish", int'(finish_req), 0);

        for (int i = 0; i < 15; i++) begin
            hold = $urandom_range(6, 0);
            mx   = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(40, 3);
            succ = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(45, 1);
            fl   = ($urandom_range(3, 0) == 0) ? $urandom_range(45, 1) : 0;
            ps   = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(40, 1);
            if ((mx == 0) && (succ == 0) && (fl == 0)) mx = 20;
            run_case($sformatf("rnd%0d", i), hold, mx, succ, fl, ps);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
